booth_r4_mul: RTL and testbench

Parametrised sequential radix-4 Booth multiplier, the next generation of the team's 8-bit `booth` block. It retires two multiplier bits per clock and supports any even operand width. A per-operation `signed_mode` input selects signed or unsigned operands. It uses the same `start`/`done` handshake, plus a `busy` flag, so a controller can issue back-to-back multiplies.

---
 rtl/booth_r4_mul.sv | 122 ++++++++++++
 tb/tb_booth_r4_mul.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/booth_r4_mul.sv
// Sequential radix-4 Booth multiplier: two multiplier bits retired per clock,
// signed or unsigned operands selected per operation, start/busy/done handshake.
module booth_r4_mul #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   outR
);

    // Extended operand width, accumulator-high width, full accumulator width.
    localparam int EW = WIDTH + 2;
    localparam int PW = WIDTH + 3;
    localparam int AW = PW + EW + 1;
    localparam int N  = WIDTH / 2 + 1;
    localparam int CW = $clog2(N + 1);

    if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_bad_width
        $error("booth_r4_mul: WIDTH must be even and at least 4");
    end

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_t;

    state_t          state_q, state_d;
    logic [EW-1:0]   m_q;
    logic [EW-1:0]   q_q;
    logic [PW-1:0]   p_q;
    logic            qm1_q;
    logic [CW-1:0]   cnt_q;

    logic            accept;
    logic            last;
    logic [EW-1:0]   a_ext;
    logic [EW-1:0]   b_ext;
    logic [PW-1:0]   m1;
    logic [PW-1:0]   m2;
    logic [PW-1:0]   addend;
    logic [PW-1:0]   p_sum;
    logic signed [AW-1:0] acc_sum;
    logic [AW-1:0]   acc_shr;
    logic [PW-1:0]   p_next;
    logic [EW-1:0]   q_next;
    logic            qm1_next;

    assign accept = start && ((state_q == StIdle) || (state_q == StDone));
    assign last   = (cnt_q == CW'(N - 1));
    assign a_ext  = {{2{signed_mode & A[WIDTH-1]}}, A};
    assign b_ext  = {{2{signed_mode & B[WIDTH-1]}}, B};
    assign busy   = (state_q == StCalc);
    assign done   = (state_q == StDone);

    // Next-state logic for the control FSM.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StCalc;
            StCalc:  if (last) state_d = StDone;
            StDone:  state_d = start ? StCalc : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Booth digit select, partial-product add and 2-bit arithmetic shift.
    always_comb begin
        m1 = {m_q[EW-1], m_q};
        m2 = {m_q, 1'b0};
        case ({q_q[1:0], qm1_q})
            3'b001, 3'b010: addend = m1;
            3'b011:         addend = m2;
            3'b100:         addend = -m2;
            3'b101, 3'b110: addend = -m1;
            default:        addend = '0;
        endcase
        p_sum    = p_q + addend;
        acc_sum  = {p_sum, q_q, qm1_q};
        acc_shr  = acc_sum >>> 2;
        p_next   = acc_shr[AW-1 -: PW];
        q_next   = acc_shr[EW:1];
        qm1_next = acc_shr[0];
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath: operand capture on accept, one Booth step per CALC cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q   <= '0;
            q_q   <= '0;
            p_q   <= '0;
            qm1_q <= 1'b0;
            cnt_q <= '0;
            outR  <= '0;
        end else if (accept) begin
            m_q   <= a_ext;
            q_q   <= b_ext;
            p_q   <= '0;
            qm1_q <= 1'b0;
            cnt_q <= '0;
        end else if (state_q == StCalc) begin
            p_q   <= p_next;
            q_q   <= q_next;
            qm1_q <= qm1_next;
            cnt_q <= cnt_q + CW'(1);
            // The product's low 2*WIDTH bits straddle the P_hi/Q boundary.
            if (last) outR <= {p_next[2*WIDTH-EW-1:0], q_next};
        end
    end

endmodule

// File: tb/tb_booth_r4_mul.sv
// Self-checking bench for booth_r4_mul at WIDTH=8 and WIDTH=16.
module tb_booth_r4_mul;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start8 = 1'b0, sm8 = 1'b0, busy8, done8;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] out8;
    logic        start16 = 1'b0, sm16 = 1'b0, busy16, done16;
    logic [15:0] a16 = '0, b16 = '0;
    logic [31:0] out16;

    booth_r4_mul #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
        .A(a8), .B(b8), .busy(busy8), .done(done8), .outR(out8)
    );

    booth_r4_mul #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
        .A(a16), .B(b16), .busy(busy16), .done(done16), .outR(out16)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // busy and done must never be high together.
    always @(negedge clk) begin
        if (!rst) begin
            n_checks++;
            if ((busy8 && done8) || (busy16 && done16)) begin
                n_fail++;
                $display("FAIL busy_done_overlap: busy8=%0b done8=%0b busy16=%0b done16=%0b",
                         busy8, done8, busy16, done16);
            end
        end
    end

    // Reference: mathematical product of the interpreted operands, truncated to 2*w bits.
    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                            input logic s, input int w);
        longint x, y, p;
        x = longint'(a) & ((longint'(1) << w) - 1);
        y = longint'(b) & ((longint'(1) << w) - 1);
        if (s && a[w-1]) x = x - (longint'(1) << w);
        if (s && b[w-1]) y = y - (longint'(1) << w);
        p = (x * y) & ((longint'(1) << (2 * w)) - 1);
        return p[31:0];
    endfunction

    // One complete operation; lat is the edge count from the start edge to done (-1 on timeout).
    task automatic run_op(input int w, input logic [15:0] a, input logic [15:0] b,
                          input logic s, output logic [31:0] r, output int lat);
        logic dn, bz;
        @(negedge clk);
        if (w == 8) begin a8 = a[7:0]; b8 = b[7:0]; sm8 = s; start8 = 1'b1; end
        else begin a16 = a; b16 = b; sm16 = s; start16 = 1'b1; end
        @(posedge clk);
        #1;
        start8 = 1'b0;
        start16 = 1'b0;
        bz = (w == 8) ? busy8 : busy16;
        check("busy_after_start", {63'b0, bz}, 64'd1);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            dn = (w == 8) ? done8 : done16;
            if (dn) begin lat = k; break; end
        end
        r = (w == 8) ? {16'b0, out8} : out16;
    endtask

    typedef struct {
        int          w;
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [31:0] exp;
    } vec_t;

    initial begin : main
        vec_t        vecs[12];
        logic [31:0] r;
        int          lat;
        int          ndone;
        int          prev_cyc;
        logic [15:0] ra[4], rb[4];
        logic        rs[4];

        vecs[0]  = '{8,  16'd25,    16'h0092, 1'b1, 32'h0000F542};
        vecs[1]  = '{8,  16'd100,   16'h00F4, 1'b1, 32'h0000FB50};
        vecs[2]  = '{8,  16'h0080,  16'h0080, 1'b1, 32'h00004000};
        vecs[3]  = '{8,  16'h0080,  16'h007F, 1'b1, 32'h0000C080};
        vecs[4]  = '{8,  16'h00FF,  16'h00FF, 1'b0, 32'h0000FE01};
        vecs[5]  = '{8,  16'h00FF,  16'h00FF, 1'b1, 32'h00000001};
        vecs[6]  = '{8,  16'h0080,  16'h0002, 1'b0, 32'h00000100};
        vecs[7]  = '{8,  16'h0080,  16'h0002, 1'b1, 32'h0000FF00};
        vecs[8]  = '{8,  16'h0000,  16'h00A5, 1'b1, 32'h00000000};
        vecs[9]  = '{16, 16'h7FFF,  16'h8000, 1'b1, 32'hC0008000};
        vecs[10] = '{16, 16'hFFFF,  16'hFFFF, 1'b0, 32'hFFFE0001};
        vecs[11] = '{16, 16'h8000,  16'h8000, 1'b0, 32'h40000000};

        // Reset and idle
        #15;
        rst = 1'b0;
        #1;
        check("rst_out8",  {48'b0, out8}, 64'd0);
        check("rst_done8", {63'b0, done8}, 64'd0);
        check("rst_busy8", {63'b0, busy8}, 64'd0);
        check("rst_out16", {32'b0, out16}, 64'd0);
        check("rst_flags16", {62'b0, busy16, done16}, 64'd0);

        // Directed table
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].s, r, lat);
            check($sformatf("vec%0d_result", i), {32'b0, r}, {32'b0, vecs[i].exp});
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].w / 2 + 1));
        end

        // Reset mid-CALC aborts: outputs clear, no done follows
        run_op(8, 16'd25, 16'h0092, 1'b1, r, lat);
        @(negedge clk);
        a8 = 8'd7; b8 = 8'd9; sm8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midcalc_rst_out",   {48'b0, out8}, 64'd0);
        check("midcalc_rst_flags", {62'b0, busy8, done8}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (done8) ndone++;
        end
        check("midcalc_rst_no_done", 64'(ndone), 64'd0);

        // Operand stability: operands change and start pulses during CALC
        @(negedge clk);
        a8 = 8'd100; b8 = 8'hF4; sm8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        a8 = 8'h55; b8 = 8'h33; sm8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'h12; b8 = 8'h34;
        ndone = 0;
        r = '0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (done8) begin ndone++; r = {16'b0, out8}; end
        end
        check("stable_result", {32'b0, r}, 64'h0000FB50);
        check("stable_one_done", 64'(ndone), 64'd1);

        // Back-to-back with start held high
        for (int i = 0; i < 4; i++) begin
            ra[i] = 16'($urandom_range(0, 255));
            rb[i] = 16'($urandom_range(0, 255));
            rs[i] = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        a8 = ra[0][7:0]; b8 = rb[0][7:0]; sm8 = rs[0]; start8 = 1'b1;
        prev_cyc = 0;
        for (int i = 0; i < 4; i++) begin
            lat = -1;
            for (int k = 1; k <= 20; k++) begin
                @(posedge clk);
                #1;
                if (done8) begin lat = k; break; end
            end
            check($sformatf("b2b%0d_seen", i), {63'b0, (lat > 0)}, 64'd1);
            check($sformatf("b2b%0d_result", i), {48'b0, out8},
                  {32'b0, ref_mul(ra[i], rb[i], rs[i], 8)});
            if (i > 0) check($sformatf("b2b%0d_interval", i), 64'(cyc - prev_cyc), 64'd6);
            prev_cyc = cyc;
            if (i < 3) begin
                a8 = ra[i+1][7:0]; b8 = rb[i+1][7:0]; sm8 = rs[i+1];
            end else begin
                start8 = 1'b0;
            end
        end

        // Random sweeps against the reference model
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 300; i++) begin
                ra[0] = 16'($urandom_range(0, 255));
                rb[0] = 16'($urandom_range(0, 255));
                run_op(8, ra[0], rb[0], 1'(s), r, lat);
                check($sformatf("rand8_s%0d_%0h_%0h", s, ra[0], rb[0]), {32'b0, r},
                      {32'b0, ref_mul(ra[0], rb[0], 1'(s), 8)});
            end
            for (int i = 0; i < 1000; i++) begin
                ra[0] = 16'($urandom);
                rb[0] = 16'($urandom);
                run_op(16, ra[0], rb[0], 1'(s), r, lat);
                check($sformatf("rand16_s%0d_%0h_%0h", s, ra[0], rb[0]), {32'b0, r},
                      {32'b0, ref_mul(ra[0], rb[0], 1'(s), 16)});
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no end, required end");
        $fatal(1, "timeout");
    end

endmodule
